// File: rtl/smoothfilter_ctrl.sv
// Purpose: feeds a pixel stream into a 3x3 smoothing filter at a paced strobe rate and
//          reloads the filter kernel from shadow registers at frame boundaries.
// Latency: 1 cycle from accepted pixel to f_strb; s_ready is held low while paced or reloading.
module smoothfilter_ctrl #(
  parameter int STRB_GAP = 8,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       f_strb,
  output logic [7:0] f_data,
  output logic       f_kernel_write,
  output logic [3:0] f_kernel_idx,
  output logic [7:0] f_kernel_data,
  input  logic       f_o_strb,
  input  logic       cfg_we,
  input  logic [3:0] cfg_idx,
  input  logic [7:0] cfg_data,
  input  logic       cfg_commit,
  output logic       cfg_pending,
  output logic       frame_in_done,
  output logic       frame_out_done
);

  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TOT = IMG_W * IMG_H;
  localparam int OW  = $clog2(TOT + 1);
  localparam logic [7:0] GAP_M1 = 8'(STRB_GAP - 1);
  // Power-up kernel: a mild Gaussian-like blur
  localparam logic [7:0] SH_RST [9] = '{8'h08, 8'h10, 8'h08,
                                        8'h10, 8'h20, 8'h10,
                                        8'h08, 8'h10, 8'h08};

  typedef enum logic {RUN, KLOAD} state_t;

  state_t         state, state_nxt;
  logic [7:0]     gcnt;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [3:0]     kidx;
  logic [7:0]     sh [9];
  logic [OW-1:0]  ocnt;
  logic           pix0;
  logic           accept;
  logic           last_pix;
  logic           kload_done;

  // pix==0 is the frame boundary: the only point where a kernel reload may start
  assign pix0       = (x == '0) && (y == '0);
  assign s_ready    = (state == RUN) && (gcnt == 8'd0) && !(pix0 && cfg_pending);
  assign accept     = s_valid && s_ready;
  assign last_pix   = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));
  assign kload_done = (state == KLOAD) && (kidx == 4'd8);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state and kernel write port; kernel outputs are quiet outside KLOAD
  always_comb begin
    state_nxt      = state;
    f_kernel_write = 1'b0;
    f_kernel_idx   = 4'd0;
    f_kernel_data  = 8'd0;
    case (state)
      RUN: begin
        if ((gcnt == 8'd0) && pix0 && cfg_pending) state_nxt = KLOAD;
      end
      KLOAD: begin
        f_kernel_write = 1'b1;
        f_kernel_idx   = kidx;
        f_kernel_data  = sh[kidx];
        if (kidx == 4'd8) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Kernel index walks 0..8 while loading, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                kidx <= 4'd0;
    else if (state != KLOAD)   kidx <= 4'd0;
    else if (kidx == 4'd8)     kidx <= 4'd0;
    else                       kidx <= kidx + 4'd1;
  end

  // Pixel issue path: strobe, data hold, pacing counter and frame-end pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_strb        <= 1'b0;
      f_data        <= 8'd0;
      gcnt          <= 8'd0;
      frame_in_done <= 1'b0;
    end else begin
      f_strb        <= accept;
      frame_in_done <= accept && last_pix;
      if (accept) begin
        f_data <= s_data;
        gcnt   <= GAP_M1;
      end else if (gcnt != 8'd0) begin
        gcnt <= gcnt - 8'd1;
      end
    end
  end

  // Raster position of the next pixel to accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x == XW'(IMG_W - 1)) begin
        x <= '0;
        y <= (y == YW'(IMG_H - 1)) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Commit request: latched in RUN only, released by the final kernel write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cfg_pending <= 1'b0;
    else if (kload_done)                   cfg_pending <= 1'b0;
    else if ((state == RUN) && cfg_commit) cfg_pending <= 1'b1;
  end

  // Shadow kernel: writable in RUN only so a load in progress sees a stable set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) sh[i] <= SH_RST[i];
    end else if ((state == RUN) && cfg_we && (cfg_idx <= 4'd8)) begin
      sh[cfg_idx] <= cfg_data;
    end
  end

  // Filter output counter, independent of the input-side state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt           <= '0;
      frame_out_done <= 1'b0;
    end else begin
      frame_out_done <= 1'b0;
      if (f_o_strb) begin
        if (ocnt == OW'(TOT - 1)) begin
          ocnt           <= '0;
          frame_out_done <= 1'b1;
        end else begin
          ocnt <= ocnt + OW'(1);
        end
      end
    end
  end

endmodule
